// File: rtl/lsf_rbin_histogram.sv
// Per-event r-bin hit histogram: counts hits per bin during an event, then
// scans and clears all bins reporting the lowest-index peak and its count.
module lsf_rbin_histogram #(
    parameter int W_bin_number_a = 7,
    parameter int RBINS          = 128,
    parameter int W_COUNT        = 5,
    parameter int MIN_HITS       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [W_bin_number_a-1:0] r_bin,
    input  logic                      r_bin_vld,
    input  logic                      evt_end,
    output logic                      busy,
    output logic                      hit_dropped,
    output logic [W_bin_number_a-1:0] max_bin,
    output logic [W_COUNT-1:0]        max_count,
    output logic                      seg_cand,
    output logic                      max_vld
);
    localparam int                 W_IDX = (RBINS > 1) ? $clog2(RBINS) : 1;
    localparam logic [W_COUNT-1:0] SAT   = '1;
    localparam logic [W_COUNT:0]   MIN_W = (W_COUNT+1)'(MIN_HITS);
    localparam logic [W_IDX-1:0]   LAST  = W_IDX'(RBINS-1);

    typedef enum logic {ACCUM, SCAN} state_t;

    state_t                    state, state_nxt;
    logic [W_COUNT-1:0]        cnt [RBINS];
    logic [W_IDX-1:0]          scan_idx;
    logic [W_bin_number_a-1:0] run_bin, cand_bin;
    logic [W_COUNT-1:0]        run_cnt, cand_cnt, cur_cnt;
    logic                      in_range, hit_ok, scan_last;

    // When the bin space is fully populated every index is legal.
    generate
        if (RBINS >= 2**W_bin_number_a) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = ({1'b0, r_bin} < (W_bin_number_a+1)'(RBINS));
        end
    endgenerate

    assign busy      = (state == SCAN);
    assign hit_ok    = (state == ACCUM) && r_bin_vld && in_range;
    assign cur_cnt   = cnt[scan_idx];
    assign scan_last = (scan_idx == LAST);

    always_comb begin
        state_nxt = state;
        cand_bin  = run_bin;
        cand_cnt  = run_cnt;
        case (state)
            ACCUM:   if (evt_end) state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
        // Strict compare keeps the lowest index on ties.
        if (cur_cnt > run_cnt) begin
            cand_bin = W_bin_number_a'(scan_idx);
            cand_cnt = cur_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < RBINS; b++) cnt[b] <= '0;
        end else begin
            for (int b = 0; b < RBINS; b++) begin
                if (state == SCAN && scan_idx == W_IDX'(b))
                    cnt[b] <= '0;
                else if (hit_ok && r_bin == W_bin_number_a'(b) && cnt[b] != SAT)
                    cnt[b] <= cnt[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            scan_idx    <= '0;
            run_bin     <= '0;
            run_cnt     <= '0;
            hit_dropped <= 1'b0;
            max_vld     <= 1'b0;
            max_bin     <= '0;
            max_count   <= '0;
            seg_cand    <= 1'b0;
        end else begin
            state       <= state_nxt;
            hit_dropped <= r_bin_vld && (state == SCAN || !in_range);
            max_vld     <= (state == SCAN) && scan_last;
            if (state == SCAN) begin
                scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
                run_bin  <= cand_bin;
                run_cnt  <= cand_cnt;
                if (scan_last) begin
                    max_bin   <= cand_bin;
                    max_count <= cand_cnt;
                    seg_cand  <= ({1'b0, cand_cnt} >= MIN_W);
                end
            end else begin
                scan_idx <= '0;
                run_bin  <= '0;
                run_cnt  <= '0;
            end
        end
    end

endmodule
